// File: rtl/lpc_reg_bank.sv
// LPC register bank: ID, BIOS select, W1C status with IRQ, scratch registers,
// and a two-key unlock sequence that write-protects the BIOS control register.
module lpc_reg_bank #(
  parameter int         NUM_REGS       = 32,
  parameter logic [7:0] ID_VALUE       = 8'h10,
  parameter logic [7:0] KEY_ADDR       = 8'h1F,
  parameter int         UNLOCK_TIMEOUT = 255
) (
  input  logic       PciReset,
  input  logic       LpcClock,
  input  logic [7:0] Addr,
  input  logic       Wr,
  input  logic       Rd,
  input  logic [7:0] DataWr,
  input  logic [7:0] EvtIn,
  input  logic       Next_Bios_latch,
  output logic [7:0] RdData,
  output logic       RdValid,
  output logic       Locked,
  output logic       Irq,
  output logic       Next_Bios,
  output logic       Active_Bios
);

  // The fixed registers at 0x04..0x06 always exist, even for tiny banks.
  localparam int         DEPTH      = (NUM_REGS < 8) ? 8 : NUM_REGS;
  localparam logic [7:0] TIMEOUT_M1 = 8'(UNLOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOCKED   = 2'b00,
    ST_KEY1     = 2'b01,
    ST_UNLOCKED = 2'b10
  } state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [7:0] r_regs [DEPTH];

  logic       w_inRange;
  logic       w_wrHit;
  logic       w_keyWr;
  logic       w_locked;
  logic [7:0] w_clr;
  logic [7:0] w_rdMux;

  assign w_inRange = ({1'b0, Addr} < 9'(NUM_REGS));
  assign w_wrHit   = Wr && w_inRange;
  assign w_keyWr   = w_wrHit && (Addr == KEY_ADDR);
  assign w_locked  = (r_state != ST_UNLOCKED);
  assign w_clr     = (w_wrHit && (Addr == 8'h05)) ? DataWr : 8'h00;

  // Unlock sequence; the KEY1 window closes after UNLOCK_TIMEOUT idle cycles.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      r_state <= ST_LOCKED;
      r_cnt   <= 8'h00;
    end else begin
      case (r_state)
        ST_LOCKED: begin
          if (w_keyWr && (DataWr == 8'h55)) begin
            r_state <= ST_KEY1;
            r_cnt   <= 8'h00;
          end
        end
        ST_KEY1: begin
          if (w_keyWr) begin
            r_state <= (DataWr == 8'hAA) ? ST_UNLOCKED : ST_LOCKED;
          end else begin
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'h01;
            if (r_cnt >= TIMEOUT_M1) r_state <= ST_LOCKED;
          end
        end
        ST_UNLOCKED: begin
          if (w_keyWr) r_state <= ST_LOCKED;
        end
        default: r_state <= ST_LOCKED;
      endcase
    end
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i == 0)      r_regs[i] <= ID_VALUE;
        else if (i == 4) r_regs[i] <= {5'b0, Next_Bios_latch, ~Next_Bios_latch, Next_Bios_latch};
        else             r_regs[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        // Status: event set wins over a same-cycle write-one-to-clear.
        if (i == 5) begin
          r_regs[i] <= (r_regs[i] & ~w_clr) | EvtIn;
        end else if (w_wrHit && (Addr == 8'(i)) && (i != 0) && (i != int'(KEY_ADDR))) begin
          if (i == 4) begin
            if (!w_locked) r_regs[i] <= {DataWr[7:2], r_regs[i][1], DataWr[0]};
          end else begin
            r_regs[i] <= DataWr;
          end
        end
      end
    end
  end

  always_comb begin
    w_rdMux = 8'hFF;
    if (w_inRange) begin
      if (Addr == KEY_ADDR) begin
        w_rdMux = {6'b0, r_state};
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (Addr == 8'(i)) w_rdMux = r_regs[i];
        end
      end
    end
  end

  // Read data comes from pre-edge state, so a same-cycle write is not visible.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      RdData  <= 8'h00;
      RdValid <= 1'b0;
    end else begin
      RdValid <= Rd;
      if (Rd) RdData <= w_rdMux;
    end
  end

  assign Locked      = w_locked;
  assign Irq         = |(r_regs[5] & r_regs[6]);
  assign Next_Bios   = r_regs[4][1];
  assign Active_Bios = r_regs[4][0];

endmodule

// File: tb/tb_lpc_reg_bank.sv
// Scoreboard bench for lpc_reg_bank: directed register/unlock scenarios plus
// random traffic checked against an array-based reference model.
module tb_lpc_reg_bank;

  localparam int         NUM_REGS = 32;
  localparam logic [7:0] ID       = 8'h10;
  localparam logic [7:0] KEY      = 8'h1F;
  localparam int         TMO      = 20;

  logic       PciReset;
  logic       LpcClock;
  logic [7:0] Addr;
  logic       Wr;
  logic       Rd;
  logic [7:0] DataWr;
  logic [7:0] EvtIn;
  logic       Next_Bios_latch;
  logic [7:0] RdData;
  logic       RdValid;
  logic       Locked;
  logic       Irq;
  logic       Next_Bios;
  logic       Active_Bios;

  lpc_reg_bank #(
    .NUM_REGS(NUM_REGS),
    .ID_VALUE(ID),
    .KEY_ADDR(KEY),
    .UNLOCK_TIMEOUT(TMO)
  ) dut (
    .PciReset(PciReset),
    .LpcClock(LpcClock),
    .Addr(Addr),
    .Wr(Wr),
    .Rd(Rd),
    .DataWr(DataWr),
    .EvtIn(EvtIn),
    .Next_Bios_latch(Next_Bios_latch),
    .RdData(RdData),
    .RdValid(RdValid),
    .Locked(Locked),
    .Irq(Irq),
    .Next_Bios(Next_Bios),
    .Active_Bios(Active_Bios)
  );

  initial LpcClock = 1'b0;
  always #5 LpcClock = ~LpcClock;

  int cycleCount = 0;
  always @(posedge LpcClock) cycleCount <= cycleCount + 1;

  typedef struct {
    logic [7:0] data;
    int         stamp;
    string      tag;
  } rdExp_t;

  rdExp_t     expQ[$];
  int         numChecks = 0;
  int         numFails  = 0;
  logic [7:0] holdData;

  // Reference model: plain register image plus unlock stage and idle count.
  logic [7:0] mregs [0:255];
  int         keyState;
  int         key1Idle;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %02h, expected %02h (cycle %0d)", name, act, exp, cycleCount);
    end
  endtask

  function automatic logic [7:0] modelRead(input logic [7:0] a);
    if (a >= NUM_REGS) return 8'hFF;
    if (a == KEY) return 8'(keyState);
    return mregs[a];
  endfunction

  task automatic modelReset(input logic nbl);
    for (int i = 0; i < 256; i++) mregs[i] = 8'h00;
    mregs[0] = ID;
    mregs[4] = nbl ? 8'h05 : 8'h02;
    keyState = 0;
    key1Idle = 0;
    holdData = 8'h00;
  endtask

  task automatic modelStep(input logic [7:0] a, input logic wr, input logic [7:0] d,
                           input logic [7:0] evt);
    logic       keyWr;
    logic [7:0] clr;
    keyWr = wr && (a == KEY);
    clr   = (wr && a == 8'h05) ? d : 8'h00;
    if (wr && a < NUM_REGS && a != 8'h00 && a != 8'h05 && a != KEY) begin
      if (a == 8'h04) begin
        if (keyState == 2) mregs[4] = {d[7:2], mregs[4][1], d[0]};
      end else begin
        mregs[a] = d;
      end
    end
    mregs[5] = (mregs[5] & ~clr) | evt;
    case (keyState)
      0: if (keyWr && d == 8'h55) begin keyState = 1; key1Idle = 0; end
      1: begin
        if (keyWr) keyState = (d == 8'hAA) ? 2 : 0;
        else begin
          key1Idle++;
          if (key1Idle >= TMO) keyState = 0;
        end
      end
      default: if (keyWr) keyState = 0;
    endcase
  endtask

  // One bus cycle, driven from a falling edge; expRd < 0 takes the model's read value.
  task automatic applyStimulus(input logic [7:0] a, input logic wr, input logic rd,
                               input logic [7:0] d, input logic [7:0] evt,
                               input int expRd, input string tag);
    rdExp_t e;
    Addr = a; Wr = wr; Rd = rd; DataWr = d; EvtIn = evt;
    if (rd) begin
      e.data  = (expRd < 0) ? modelRead(a) : 8'(expRd);
      e.stamp = cycleCount;
      e.tag   = tag;
      expQ.push_back(e);
    end
    modelStep(a, wr, d, evt);
    @(posedge LpcClock);
    @(negedge LpcClock);
    Wr = 1'b0; Rd = 1'b0; EvtIn = 8'h00;
    checkOutput("Locked", {7'b0, Locked}, {7'b0, keyState != 2});
    checkOutput("Irq", {7'b0, Irq}, {7'b0, (mregs[5] & mregs[6]) != 8'h00});
    checkOutput("Next_Bios", {7'b0, Next_Bios}, {7'b0, mregs[4][1]});
    checkOutput("Active_Bios", {7'b0, Active_Bios}, {7'b0, mregs[4][0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, 8'h00, 8'h00, -1, "idle");
  endtask

  // Reset asserted mid-cycle; optionally with a read strobe already on the bus.
  task automatic doReset(input logic nbl, input logic midRead);
    if (midRead) begin Addr = 8'h10; Rd = 1'b1; end
    #2;
    PciReset = 1'b0;
    Next_Bios_latch = nbl;
    modelReset(nbl);
    @(negedge LpcClock);
    Rd = 1'b0;
    checkOutput("resetRdValid", {7'b0, RdValid}, 8'h00);
    checkOutput("resetRdData", RdData, 8'h00);
    checkOutput("resetLocked", {7'b0, Locked}, 8'h01);
    checkOutput("resetNextBios", {7'b0, Next_Bios}, {7'b0, ~nbl});
    @(negedge LpcClock);
    PciReset = 1'b1;
    Next_Bios_latch = ~nbl;
  endtask

  // Monitor: pops one expectation per RdValid pulse, else checks RdData holds.
  initial begin
    rdExp_t e;
    forever begin
      @(negedge LpcClock);
      if (PciReset === 1'b1) begin
        if (RdValid === 1'b1) begin
          if (expQ.size() == 0) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL unexpectedRdValid: got RdValid=1 data %02h, expected no read", RdData);
          end else begin
            e = expQ.pop_front();
            checkOutput({"rd ", e.tag}, RdData, e.data);
            checkOutput("rdLatency", 8'(cycleCount - e.stamp), 8'd1);
            holdData = e.data;
          end
        end else begin
          checkOutput("rdHold", RdData, holdData);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    numFails++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

  initial begin
    logic [7:0] a, d, evt;
    int         r;
    PciReset = 1'b0; Next_Bios_latch = 1'b1;
    Addr = 8'h00; Wr = 1'b0; Rd = 1'b0; DataWr = 8'h00; EvtIn = 8'h00;
    modelReset(1'b1);
    repeat (3) @(negedge LpcClock);
    checkOutput("resetRdData", RdData, 8'h00);
    checkOutput("resetRdValid", {7'b0, RdValid}, 8'h00);
    PciReset = 1'b1;
    Next_Bios_latch = 1'b0;

    // Reset values and BIOS select latched with Next_Bios_latch=1
    applyStimulus(8'h00, 0, 1, 8'h00, 8'h00, 8'h10, "id");
    applyStimulus(8'h04, 0, 1, 8'h00, 8'h00, 8'h05, "bios reset");
    applyStimulus(8'h05, 0, 1, 8'h00, 8'h00, 8'h00, "status reset");
    applyStimulus(KEY,   0, 1, 8'h00, 8'h00, 8'h00, "key reset");
    checkOutput("nextBiosReset", {7'b0, Next_Bios}, 8'h00);
    checkOutput("activeBiosReset", {7'b0, Active_Bios}, 8'h01);

    // Locked write dropped, then unlock and write
    applyStimulus(8'h04, 1, 0, 8'hFE, 8'h00, -1, "");
    applyStimulus(8'h04, 0, 1, 8'h00, 8'h00, 8'h05, "bios locked");
    applyStimulus(KEY,   1, 0, 8'h55, 8'h00, -1, "");
    applyStimulus(KEY,   0, 1, 8'h00, 8'h00, 8'h01, "key1 state");
    applyStimulus(KEY,   1, 0, 8'hAA, 8'h00, -1, "");
    applyStimulus(8'h04, 1, 0, 8'hFE, 8'h00, -1, "");
    applyStimulus(8'h04, 0, 1, 8'h00, 8'h00, 8'hFC, "bios unlocked");
    checkOutput("unlocked", {7'b0, Locked}, 8'h00);
    applyStimulus(8'h00, 1, 0, 8'h77, 8'h00, -1, "");
    applyStimulus(8'h00, 0, 1, 8'h00, 8'h00, 8'h10, "id read-only");
    applyStimulus(KEY,   1, 0, 8'h00, 8'h00, -1, "");
    applyStimulus(KEY,   0, 1, 8'h00, 8'h00, 8'h00, "relocked");

    // Timeout: AA after TMO idle cycles is too late, after TMO-1 is accepted
    applyStimulus(KEY, 1, 0, 8'h55, 8'h00, -1, "");
    idle(TMO);
    applyStimulus(KEY, 1, 0, 8'hAA, 8'h00, -1, "");
    applyStimulus(KEY, 0, 1, 8'h00, 8'h00, 8'h00, "timeout");
    checkOutput("timeoutLocked", {7'b0, Locked}, 8'h01);
    applyStimulus(KEY, 1, 0, 8'h55, 8'h00, -1, "");
    idle(TMO - 1);
    applyStimulus(KEY, 1, 0, 8'hAA, 8'h00, -1, "");
    applyStimulus(KEY, 0, 1, 8'h00, 8'h00, 8'h02, "edge of window");
    applyStimulus(KEY, 1, 0, 8'h55, 8'h00, -1, "");
    applyStimulus(KEY, 1, 0, 8'h12, 8'h00, -1, "");
    applyStimulus(KEY, 1, 0, 8'h55, 8'h00, -1, "");
    applyStimulus(KEY, 1, 0, 8'h12, 8'h00, -1, "");
    applyStimulus(KEY, 0, 1, 8'h00, 8'h00, 8'h00, "bad key2");

    // Status set/clear and interrupt
    applyStimulus(8'h00, 0, 0, 8'h00, 8'h03, -1, "");
    applyStimulus(8'h06, 1, 0, 8'h02, 8'h00, -1, "");
    checkOutput("irqSet", {7'b0, Irq}, 8'h01);
    applyStimulus(8'h05, 1, 0, 8'h02, 8'h02, -1, "");
    applyStimulus(8'h05, 0, 1, 8'h00, 8'h00, 8'h03, "status set wins");
    applyStimulus(8'h05, 1, 0, 8'h02, 8'h00, -1, "");
    applyStimulus(8'h05, 0, 1, 8'h00, 8'h00, 8'h01, "status cleared");
    checkOutput("irqClear", {7'b0, Irq}, 8'h00);

    // Scratch, out of range, same-cycle read/write
    applyStimulus(8'h10, 1, 0, 8'hA5, 8'h00, -1, "");
    applyStimulus(8'h10, 0, 1, 8'h00, 8'h00, 8'hA5, "scratch");
    applyStimulus(8'h11, 0, 1, 8'h00, 8'h00, 8'h00, "neighbour");
    applyStimulus(8'hFF, 0, 1, 8'h00, 8'h00, 8'hFF, "out of range");
    applyStimulus(8'h20, 1, 0, 8'h5A, 8'h00, -1, "");
    applyStimulus(8'h20, 0, 1, 8'h00, 8'h00, 8'hFF, "oor write");
    applyStimulus(8'h10, 1, 1, 8'h3C, 8'h00, 8'hA5, "rd+wr same cycle");
    applyStimulus(8'h10, 0, 1, 8'h00, 8'h00, 8'h3C, "after rd+wr");

    // Reset with Next_Bios_latch=0, mid-unlock and mid-read reset
    doReset(1'b0, 1'b0);
    applyStimulus(8'h04, 0, 1, 8'h00, 8'h00, 8'h02, "bios latch0");
    applyStimulus(8'h10, 0, 1, 8'h00, 8'h00, 8'h00, "scratch cleared");
    applyStimulus(KEY, 1, 0, 8'h55, 8'h00, -1, "");
    doReset(1'b1, 1'b1);
    idle(2);
    applyStimulus(KEY, 1, 0, 8'hAA, 8'h00, -1, "");
    applyStimulus(KEY, 0, 1, 8'h00, 8'h00, 8'h00, "reset mid-unlock");

    // Randomized traffic with periodic unlock attempts
    for (int n = 0; n < 500; n++) begin
      if (n % 60 == 5) begin
        applyStimulus(KEY, 1, 0, 8'h55, 8'h00, -1, "");
        applyStimulus(KEY, 1, 0, 8'hAA, 8'h00, -1, "");
      end
      r = int'($urandom_range(0, 9));
      if (r < 6)      a = 8'($urandom_range(0, 31));
      else if (r < 8) begin
        case ($urandom_range(0, 3))
          0: a = 8'h04;
          1: a = 8'h05;
          2: a = 8'h06;
          default: a = KEY;
        endcase
      end else a = 8'($urandom_range(32, 255));
      if (a == KEY) begin
        case ($urandom_range(0, 2))
          0: d = 8'h55;
          1: d = 8'hAA;
          default: d = 8'($urandom);
        endcase
      end else d = 8'($urandom);
      evt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      applyStimulus(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d, evt, -1, "random");
    end

    idle(3);
    if (expQ.size() != 0) begin
      numChecks++;
      numFails++;
      $display("[TB] FAIL pendingReads: got %0d outstanding, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
